// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : ID-stage instruction fields presented to the hazard unit
//                and the stall/forward-select/MDU-busy results it returns.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_mdu;
    logic       id_uses_hilo;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       mdu_busy;

    // Pipeline side: presents the ID instruction, consumes the results.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, id_is_mdu, id_uses_hilo, flush,
        input  stall, fwd_a_sel, fwd_b_sel, mdu_busy
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
               id_reg_write, id_mem_read, id_is_mdu, id_uses_hilo, flush,
        output stall, fwd_a_sel, fwd_b_sel, mdu_busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Tracks destination tags through EX/MEM/WB, drives the EX
//                operand forward selects, and stalls ID on load-use and
//                MDU (HI/LO not ready) hazards. MDU_LATENCY legal: 1..15.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MDU_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } tag_t;

    localparam logic [3:0] c_mdu_latency = 4'(MDU_LATENCY);
    localparam tag_t       c_bubble      = '0;

    tag_t       r_ex_tag;
    tag_t       r_mem_tag;
    tag_t       r_wb_tag;
    logic [4:0] r_ex_rs;
    logic [4:0] r_ex_rt;
    logic       r_ex_uses_rs;
    logic       r_ex_uses_rt;
    logic [3:0] r_mdu_cnt;

    logic w_load_use;
    logic w_mdu_hazard;
    logic w_stall;
    logic w_accept;

    // Select for one EX operand: the youngest in-flight writer wins; r0 never forwards.
    function automatic logic [1:0] fwd_sel(input tag_t mem_tag, input tag_t wb_tag,
                                           input logic [4:0] src, input logic uses);
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && src != 5'd0) begin
            if (mem_tag.valid && mem_tag.reg_write && mem_tag.dest == src)
                sel = 2'b01;
            else if (wb_tag.valid && wb_tag.reg_write && wb_tag.dest == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    // Hazard detection and ID acceptance; flush suppresses any stall.
    always_comb begin
        w_load_use   = r_ex_tag.valid && r_ex_tag.mem_read && (r_ex_tag.dest != 5'd0) &&
                       ((bus.id_uses_rs && bus.id_rs == r_ex_tag.dest) ||
                        (bus.id_uses_rt && bus.id_rt == r_ex_tag.dest));
        w_mdu_hazard = (r_mdu_cnt != 4'd0) && (bus.id_uses_hilo || bus.id_is_mdu);
        w_stall      = bus.id_valid && !bus.flush && (w_load_use || w_mdu_hazard);
        w_accept     = bus.id_valid && !bus.flush && !w_stall;
    end

    // Outputs are derived from registered state (fwd) or current ID inputs (stall).
    always_comb begin
        bus.stall     = w_stall;
        bus.fwd_a_sel = fwd_sel(r_mem_tag, r_wb_tag, r_ex_rs, r_ex_uses_rs);
        bus.fwd_b_sel = fwd_sel(r_mem_tag, r_wb_tag, r_ex_rt, r_ex_uses_rt);
        bus.mdu_busy  = (r_mdu_cnt != 4'd0);
    end

    // Tag pipeline: MEM/WB always advance; EX takes the ID instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_tag     <= c_bubble;
            r_mem_tag    <= c_bubble;
            r_wb_tag     <= c_bubble;
            r_ex_rs      <= 5'd0;
            r_ex_rt      <= 5'd0;
            r_ex_uses_rs <= 1'b0;
            r_ex_uses_rt <= 1'b0;
        end else begin
            r_wb_tag  <= r_mem_tag;
            r_mem_tag <= r_ex_tag;
            if (w_accept) begin
                r_ex_tag     <= '{valid: 1'b1, dest: bus.id_dest,
                                  reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
                r_ex_rs      <= bus.id_rs;
                r_ex_rt      <= bus.id_rt;
                r_ex_uses_rs <= bus.id_uses_rs;
                r_ex_uses_rt <= bus.id_uses_rt;
            end else begin
                r_ex_tag     <= c_bubble;
                r_ex_rs      <= 5'd0;
                r_ex_rt      <= 5'd0;
                r_ex_uses_rs <= 1'b0;
                r_ex_uses_rt <= 1'b0;
            end
        end
    end

    // MDU countdown: reload on an accepted mult/div, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mdu_cnt <= 4'd0;
        else if (w_accept && bus.id_is_mdu)
            r_mdu_cnt <= c_mdu_latency;
        else if (r_mdu_cnt != 4'd0)
            r_mdu_cnt <= r_mdu_cnt - 4'd1;
    end

    // A load in MEM has no data yet; the load-use stall must keep it from forwarding.
    a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_mem_tag.valid && r_mem_tag.mem_read &&
          (bus.fwd_a_sel == 2'b01 || bus.fwd_b_sel == 2'b01)));

    // Bubbles carry all-zero fields, so an invalid tag is never partially populated.
    a_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
        r_wb_tag.valid || (r_wb_tag == c_bubble));
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed pipeline sequences plus random traffic for
//                hazard_unit, checked against a stage-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if bus ();

    hazard_unit #(.MDU_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an instruction list indexed 0=EX, 1=MEM, 2=WB.
    typedef struct {
        bit         valid;
        logic [4:0] dest;
        bit         rw;
        bit         mr;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         urs;
        bit         urt;
    } instr_t;

    instr_t m_pipe [3];
    int     m_mdu_age;   // cycles since the last mult/div entered EX

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '{default: 0};
        m_mdu_age = 1000;
    endtask

    function automatic bit writes(input instr_t s, input logic [4:0] r);
        return s.valid && s.rw && s.dest != 5'd0 && s.dest == r;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src, input bit uses);
        if (!uses) return 2'd0;
        for (int s = 1; s <= 2; s++)
            if (writes(m_pipe[s], src)) return 2'(s);
        return 2'd0;
    endfunction

    function automatic bit exp_busy();
        return m_mdu_age >= 1 && m_mdu_age <= LAT;
    endfunction

    function automatic bit exp_stall();
        bit         hazard;
        logic [4:0] loaded;
        loaded = (m_pipe[0].valid && m_pipe[0].mr) ? m_pipe[0].dest : 5'd0;
        hazard = (loaded != 5'd0) &&
                 ((bus.id_uses_rs && bus.id_rs == loaded) || (bus.id_uses_rt && bus.id_rt == loaded));
        hazard = hazard || (exp_busy() && (bus.id_uses_hilo || bus.id_is_mdu));
        return bus.id_valid && !bus.flush && hazard;
    endfunction

    task automatic issue(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                         input int dest, input bit rw, input bit mr, input bit mdu,
                         input bit hilo, input bit fl);
        bus.id_valid     = v;
        bus.id_rs        = 5'(rs);
        bus.id_uses_rs   = urs;
        bus.id_rt        = 5'(rt);
        bus.id_uses_rt   = urt;
        bus.id_dest      = 5'(dest);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_is_mdu    = mdu;
        bus.id_uses_hilo = hilo;
        bus.flush        = fl;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Mid-cycle sample: every output against the model.
    task automatic mid();
        #4;
        chk("model_stall", 4'(bus.stall), 4'(exp_stall()));
        chk("model_fwd_a", 4'(bus.fwd_a_sel), 4'(exp_fwd(m_pipe[0].rs, m_pipe[0].urs)));
        chk("model_fwd_b", 4'(bus.fwd_b_sel), 4'(exp_fwd(m_pipe[0].rt, m_pipe[0].urt)));
        chk("model_busy", 4'(bus.mdu_busy), 4'(exp_busy()));
    endtask

    // Clock edge: advance the model the way the pipeline moves instructions.
    task automatic edge_step();
        bit     acc;
        bit     is_mdu;
        instr_t nxt;
        acc    = bus.id_valid && !bus.flush && !exp_stall();
        is_mdu = bus.id_is_mdu;
        nxt    = '{default: 0};
        if (acc) nxt = '{1'b1, bus.id_dest, bus.id_reg_write, bus.id_mem_read,
                         bus.id_rs, bus.id_rt, bus.id_uses_rs, bus.id_uses_rt};
        @(posedge clk);
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = nxt;
        if (acc && is_mdu) m_mdu_age = 1;
        else if (m_mdu_age < 1000) m_mdu_age++;
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) begin mid(); edge_step(); end
    endtask

    initial begin
        model_reset();
        nop();
        #2;
        chk("reset_stall", 4'(bus.stall), 4'd0);
        chk("reset_fwd_a", 4'(bus.fwd_a_sel), 4'd0);
        chk("reset_fwd_b", 4'(bus.fwd_b_sel), 4'd0);
        chk("reset_busy", 4'(bus.mdu_busy), 4'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // add r3,r1,r2 ; sub r4,r3,r5 -> forward from MEM
        issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); mid(); edge_step();
        issue(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0); mid();
        chk("b2b_stall", 4'(bus.stall), 4'd0); edge_step();
        nop(); mid();
        chk("b2b_fwd_a", 4'(bus.fwd_a_sel), 4'd1); edge_step();
        drain();

        // add r3 ; nop ; or r6,r0,r3 -> forward from WB
        issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); mid(); edge_step();
        nop(); mid(); edge_step();
        issue(1, 0, 1, 3, 1, 6, 1, 0, 0, 0, 0); mid(); edge_step();
        nop(); mid();
        chk("dist2_fwd_b", 4'(bus.fwd_b_sel), 4'd2);
        chk("dist2_fwd_a_r0", 4'(bus.fwd_a_sel), 4'd0); edge_step();
        drain();

        // add r3 ; add r3 ; or r6,r0,r3 -> MEM wins over WB
        issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); mid(); edge_step();
        issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); mid(); edge_step();
        issue(1, 0, 1, 3, 1, 6, 1, 0, 0, 0, 0); mid(); edge_step();
        nop(); mid();
        chk("prio_fwd_b", 4'(bus.fwd_b_sel), 4'd1); edge_step();
        drain();

        // lw r2,0(r1) ; add r4,r2,r2 -> one stall cycle, then WB forwarding
        issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0); mid(); edge_step();
        issue(1, 2, 1, 2, 1, 4, 1, 0, 0, 0, 0); mid();
        chk("lu_stall1", 4'(bus.stall), 4'd1); edge_step();
        mid();
        chk("lu_stall2", 4'(bus.stall), 4'd0); edge_step();
        nop(); mid();
        chk("lu_fwd_a", 4'(bus.fwd_a_sel), 4'd2);
        chk("lu_fwd_b", 4'(bus.fwd_b_sel), 4'd2); edge_step();
        drain();

        // writes to r0 are never forwarded and lw r0 never stalls
        issue(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0); mid(); edge_step();
        issue(1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0); mid(); edge_step();
        nop(); mid();
        chk("r0_fwd_a", 4'(bus.fwd_a_sel), 4'd0); edge_step();
        issue(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0); mid(); edge_step();
        issue(1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0); mid();
        chk("r0_lw_stall", 4'(bus.stall), 4'd0); edge_step();
        drain();

        // mult ; mfhi -> LAT stall cycles with busy high
        issue(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); mid(); edge_step();
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        for (int i = 0; i < LAT; i++) begin
            mid();
            chk("mdu_stall_hi", 4'(bus.stall), 4'd1);
            chk("mdu_busy_hi", 4'(bus.mdu_busy), 4'd1);
            edge_step();
        end
        mid();
        chk("mdu_stall_lo", 4'(bus.stall), 4'd0);
        chk("mdu_busy_lo", 4'(bus.mdu_busy), 4'd0); edge_step();
        drain();

        // mult ; unrelated add while busy -> no stall
        issue(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); mid(); edge_step();
        issue(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0); mid();
        chk("mdu_add_stall", 4'(bus.stall), 4'd0);
        chk("mdu_add_busy", 4'(bus.mdu_busy), 4'd1); edge_step();
        drain();

        // flush during a load-use stall -> stall drops, EX gets a bubble
        issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0); mid(); edge_step();
        issue(1, 2, 1, 0, 0, 4, 1, 0, 0, 0, 1); mid();
        chk("flush_stall", 4'(bus.stall), 4'd0); edge_step();
        issue(1, 4, 1, 0, 0, 8, 1, 0, 0, 0, 0); mid(); edge_step();
        nop(); mid();
        chk("flush_bubble", 4'(bus.fwd_a_sel), 4'd0); edge_step();
        drain();

        // reset asserted mid-MDU clears busy immediately
        issue(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); mid(); edge_step();
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        #2;
        chk("pre_rst_busy", 4'(bus.mdu_busy), 4'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 4'(bus.mdu_busy), 4'd0);
        chk("rst_stall", 4'(bus.stall), 4'd0);
        #1 rst_n = 1'b1;
        model_reset();
        nop();
        edge_step();

        // random traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bit rw;
            bit mr;
            rw = ($urandom % 4) != 0;
            mr = rw && (($urandom % 4) == 0);
            issue(($urandom % 8) != 0,
                  $urandom_range(0, 3), $urandom % 2,
                  $urandom_range(0, 3), $urandom % 2,
                  $urandom_range(0, 3), rw, mr,
                  ($urandom % 12) == 0, ($urandom % 8) == 0,
                  ($urandom % 8) == 0);
            mid();
            edge_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
